seg_scan_capture: RTL
=====================

# seg_scan_capture

Monitors the multiplexed 7-segment bus driven by the display scanner and reconstructs the three 6-bit values (total, current, water level) being shown. It samples the active-low segment and anode lines every clock, decodes each glyph back to its digit code, and assembles a full 8-position frame. On a complete, consistent frame it publishes the decoded values with a one-cycle valid pulse. It serves as a bench-side and on-chip self-check that closes the loop on the display path.

## Interface
- HOLD_MAX, 255: maximum consecutive cycles one position may stay active before the frame is aborted.
- clk  in  1  system clock; also the scanner's clock.
- rst_  in  1  reset, synchronous, active-low.
- uSEG_  in  8  segment lines, active-low; bit 7 is the decimal point, always high.
- uAN_  in  8  anode lines, active-low; bit k low selects position k.
- yTot  out  6  decoded total value (positions 7,6).
- yCur  out  6  decoded current value (positions 4,3).
- yWat  out  6  decoded water value (positions 1,0).
- yValid  out  1  one-cycle pulse: yTot/yCur/yWat just updated.
- yErr  out  1  one-cycle pulse: frame aborted.
- yErrCode  out  2  cause, valid while yErr=1: 01 anode not one-hot, 10 bad glyph/value, 11 sequence/timeout.

## Operation
- Stage 1: register uSEG_/uAN_ unconditionally.
- Stage 2: classify the registered sample. All anodes high: idle sample, ignored, does not count toward HOLD_MAX. Exactly one low: valid sample at position p. Two or more low: abort, code 01.
- Glyph decode: 11000000..10010000 -> 0..9; 10001100 -> 10; 10001000 -> 11; 11111111 -> 15; any other pattern -> abort, code 10.
- State machine:
  - WAIT: ignore samples until p=0, then store digit[0] and go to COLLECT with expected position 0.
  - COLLECT: same p as previous: overwrite digit[p] and increment the hold counter. When the hold counter exceeds HOLD_MAX: abort, code 11. p = previous+1: store, reset the hold counter. Any other p: abort, code 11. A stored p=7 moves to CHECK.
  - CHECK (one cycle): positions 5 and 2 must be 15. Pair decode (hi,lo): (15,15) -> 55; (8,8) -> 56; (10,11) -> 57; both 0..9 with hi*10+lo <= 63 -> that value; otherwise abort, code 10. On success, update all three outputs together, pulse yValid, and return to WAIT.
- Abort: pulse yErr with yErrCode, discard partial digits, go to WAIT. Outputs hold their last good frame.
- The hold counter saturates. Counter width is clog2(HOLD_MAX+1)+1.

## Timing
- Reset, in the cycle after rst_ is sampled low: yTot=yCur=yWat=0, yValid=0, yErr=0, yErrCode=00, state WAIT, digits cleared.
- Reset mid-frame discards the frame and produces no yErr.
- Latency: the position-7 sample present on the inputs at edge N is captured into stage 1 at N, stored in COLLECT at N+1, and checked at N+2. yValid and the new outputs are visible after edge N+2.
- Error latency: yErr is visible after edge N+1 for anode/glyph faults and out-of-order positions. Value faults appear at N+2.
- A free-running scanner (one position per clock) yields yValid every 8 cycles, with a WAIT->COLLECT entry on the same cycle the p=0 sample is classified. No frame is lost between consecutive frames.
- yValid and yErr are never high together.

## Structure
- Shared package `seg_pkg`:
  - Glyph pattern constants for codes 0..11 and blank.
  - Code constants BLANK=15, DASH_HI=10, DASH_LO=11.
  - Sentinel values 55/56/57.
  - Error code enum.
  - State enum {WAIT, COLLECT, CHECK}.
- One sub-module `_seg_glyph_decode`: combinational pattern -> {code[3:0], ok}. Instantiate it once.
- Pair-to-value conversion is a function in `seg_pkg`.

## Test plan
- Free-running scan of a frame encoding Tot=42, Cur=7, Wat=63 -> yValid after cycle 10, outputs 42/7/63, and repeats every 8 cycles.
- Sentinels: Tot pair (15,15), Cur (8,8), Wat (10,11) -> 55/56/57.
- Anode 8'b11110011 injected mid-frame -> yErr with code 01, outputs keep their previous frame, next clean frame -> yValid.
- Segment 8'b01010101 at position 3 -> yErr code 10. Digits (6,4) at positions 1,0 (value 64) -> yErr code 10 at CHECK.
- Scan order 0,1,3 -> yErr code 11. With HOLD_MAX=3, position 2 held for 5 cycles -> yErr code 11. Position held for 3 cycles -> no error.
- rst_ low at position 4 of a frame -> outputs 0, no yErr. The following full frame -> yValid.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the 7-segment scan capture.
// Glyph patterns are active-low with bit 7 (decimal point) held high.
package seg_pkg;

  localparam int unsigned NPOS   = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned VAL_W  = 6;

  localparam logic [7:0] GLYPH_0       = 8'hC0;
  localparam logic [7:0] GLYPH_1       = 8'hF9;
  localparam logic [7:0] GLYPH_2       = 8'hA4;
  localparam logic [7:0] GLYPH_3       = 8'hB0;
  localparam logic [7:0] GLYPH_4       = 8'h99;
  localparam logic [7:0] GLYPH_5       = 8'h92;
  localparam logic [7:0] GLYPH_6       = 8'h82;
  localparam logic [7:0] GLYPH_7       = 8'hF8;
  localparam logic [7:0] GLYPH_8       = 8'h80;
  localparam logic [7:0] GLYPH_9       = 8'h90;
  localparam logic [7:0] GLYPH_DASH_HI = 8'h8C;
  localparam logic [7:0] GLYPH_DASH_LO = 8'h88;
  localparam logic [7:0] GLYPH_BLANK   = 8'hFF;

  localparam logic [CODE_W-1:0] BLANK   = 4'd15;
  localparam logic [CODE_W-1:0] DASH_HI = 4'd10;
  localparam logic [CODE_W-1:0] DASH_LO = 4'd11;

  localparam logic [VAL_W-1:0] SENT_BLANK = 6'd55;
  localparam logic [VAL_W-1:0] SENT_EIGHT = 6'd56;
  localparam logic [VAL_W-1:0] SENT_DASH  = 6'd57;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ANODE = 2'b01,
    ERR_VALUE = 2'b10,
    ERR_SEQ   = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_e;

  typedef struct packed {
    logic             ok;
    logic [VAL_W-1:0] value;
  } pair_res_t;

  typedef struct packed {
    logic [VAL_W-1:0] tot;
    logic [VAL_W-1:0] cur;
    logic [VAL_W-1:0] wat;
  } frame_t;

  // Convert a (hi, lo) digit-code pair into the displayed 6-bit value.
  function automatic pair_res_t pair_to_value(input logic [CODE_W-1:0] hi,
                                              input logic [CODE_W-1:0] lo);
    pair_res_t  r;
    logic [6:0] sum;
    r   = '0;
    sum = 7'(hi) * 7'd10 + 7'(lo);
    if (hi == BLANK && lo == BLANK) begin
      r = '{ok: 1'b1, value: SENT_BLANK};
    end else if (hi == 4'd8 && lo == 4'd8) begin
      r = '{ok: 1'b1, value: SENT_EIGHT};
    end else if (hi == DASH_HI && lo == DASH_LO) begin
      r = '{ok: 1'b1, value: SENT_DASH};
    end else if (hi <= 4'd9 && lo <= 4'd9 && sum <= 7'd63) begin
      r = '{ok: 1'b1, value: sum[5:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_capture_glyph_decode.sv
// seg_scan_capture_glyph_decode: active-low segment pattern -> digit code.
//   i_seg   segment pattern (bit 7 = decimal point)
//   o_code  decoded code 0..11 or 15 (blank)
//   o_ok    pattern is one of the recognised glyphs
module seg_scan_capture_glyph_decode
  import seg_pkg::*;
(
  input  logic [7:0]        i_seg,
  output logic [CODE_W-1:0] o_code,
  output logic              o_ok
);

  always_comb begin
    o_code = '0;
    o_ok   = 1'b1;
    case (i_seg)
      GLYPH_0:       o_code = 4'd0;
      GLYPH_1:       o_code = 4'd1;
      GLYPH_2:       o_code = 4'd2;
      GLYPH_3:       o_code = 4'd3;
      GLYPH_4:       o_code = 4'd4;
      GLYPH_5:       o_code = 4'd5;
      GLYPH_6:       o_code = 4'd6;
      GLYPH_7:       o_code = 4'd7;
      GLYPH_8:       o_code = 4'd8;
      GLYPH_9:       o_code = 4'd9;
      GLYPH_DASH_HI: o_code = DASH_HI;
      GLYPH_DASH_LO: o_code = DASH_LO;
      GLYPH_BLANK:   o_code = BLANK;
      default:       o_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reconstructs total/current/water values from the
// multiplexed active-low 7-segment bus and publishes complete frames.
//   clk, rst_        clock, synchronous active-low reset
//   uSEG_, uAN_      segment / anode lines (active-low)
//   yTot/yCur/yWat   last good decoded frame
//   yValid           one-cycle pulse when the frame outputs update
//   yErr, yErrCode   one-cycle abort pulse and its cause
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 255
)
(
  input  logic             clk,
  input  logic             rst_,
  input  logic [7:0]       uSEG_,
  input  logic [7:0]       uAN_,
  output logic [VAL_W-1:0] yTot,
  output logic [VAL_W-1:0] yCur,
  output logic [VAL_W-1:0] yWat,
  output logic             yValid,
  output logic             yErr,
  output logic [1:0]       yErrCode
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  logic [7:0]                    r_seg;
  logic [7:0]                    r_an;
  state_e                        r_state;
  logic [NPOS-1:0][CODE_W-1:0]   r_dig;
  logic [2:0]                    r_pos;
  logic [CNT_W-1:0]              r_cnt;
  frame_t                        r_frame;
  logic                          r_valid;
  logic                          r_err;
  err_code_e                     r_code;

  logic [7:0]                    w_an_act;
  logic                          w_single;
  logic                          w_multi;
  logic [2:0]                    w_pos;
  logic [CODE_W-1:0]             w_gcode;
  logic                          w_gok;
  logic [CNT_W-1:0]              w_cnt_inc;
  pair_res_t                     w_tot_res;
  pair_res_t                     w_cur_res;
  pair_res_t                     w_wat_res;
  logic                          w_chk_ok;

  state_e                        w_state_nxt;
  logic [NPOS-1:0][CODE_W-1:0]   w_dig_nxt;
  logic [2:0]                    w_pos_nxt;
  logic [CNT_W-1:0]              w_cnt_nxt;
  frame_t                        w_frame_nxt;
  logic                          w_valid_nxt;
  logic                          w_abort;
  err_code_e                     w_abort_code;

  seg_scan_capture_glyph_decode u_glyph (
    .i_seg  (r_seg),
    .o_code (w_gcode),
    .o_ok   (w_gok)
  );

  // Anode classification: idle, exactly one active, or several active.
  assign w_an_act = ~r_an;
  assign w_single = (w_an_act != 8'h00) && ((w_an_act & (w_an_act - 8'd1)) == 8'h00);
  assign w_multi  = (w_an_act != 8'h00) && !w_single;

  always_comb begin
    w_pos = '0;
    for (int k = 0; k < int'(NPOS); k++) begin
      if (w_an_act[k]) w_pos = 3'(k);
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

  assign w_tot_res = pair_to_value(r_dig[7], r_dig[6]);
  assign w_cur_res = pair_to_value(r_dig[4], r_dig[3]);
  assign w_wat_res = pair_to_value(r_dig[1], r_dig[0]);
  assign w_chk_ok  = (r_dig[5] == BLANK) && (r_dig[2] == BLANK) &&
                     w_tot_res.ok && w_cur_res.ok && w_wat_res.ok;

  // Next-state and output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_dig_nxt    = r_dig;
    w_pos_nxt    = r_pos;
    w_cnt_nxt    = r_cnt;
    w_frame_nxt  = r_frame;
    w_valid_nxt  = 1'b0;
    w_abort      = 1'b0;
    w_abort_code = ERR_NONE;

    case (r_state)
      WAIT: begin
        if (w_multi) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_ANODE;
        end else if (w_single && w_pos == 3'd0) begin
          if (!w_gok) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_VALUE;
          end else begin
            w_dig_nxt    = '0;
            w_dig_nxt[0] = w_gcode;
            w_pos_nxt    = 3'd0;
            w_cnt_nxt    = '0;
            w_state_nxt  = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (w_multi) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_ANODE;
        end else if (w_single) begin
          if (!w_gok) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_VALUE;
          end else if (w_pos == r_pos) begin
            w_dig_nxt[w_pos] = w_gcode;
            w_cnt_nxt        = w_cnt_inc;
            if (w_cnt_inc > CNT_LIMIT) begin
              w_abort      = 1'b1;
              w_abort_code = ERR_SEQ;
            end
          end else if (w_pos == 3'(r_pos + 3'd1)) begin
            w_dig_nxt[w_pos] = w_gcode;
            w_pos_nxt        = w_pos;
            w_cnt_nxt        = '0;
            if (w_pos == 3'd7) w_state_nxt = CHECK;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_SEQ;
          end
        end
      end

      CHECK: begin
        if (!w_chk_ok) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_VALUE;
        end else begin
          w_valid_nxt = 1'b1;
          w_frame_nxt = '{tot: w_tot_res.value, cur: w_cur_res.value, wat: w_wat_res.value};
          w_dig_nxt   = '0;
          w_pos_nxt   = 3'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT;
          // A back-to-back scanner presents the next frame's position 0 now.
          if (w_single && w_pos == 3'd0 && w_gok) begin
            w_dig_nxt[0] = w_gcode;
            w_state_nxt  = COLLECT;
          end
        end
      end

      default: begin
        w_state_nxt = WAIT;
      end
    endcase

    // Abort discards the partial frame; frame outputs keep their last value.
    if (w_abort) begin
      w_state_nxt = WAIT;
      w_dig_nxt   = '0;
      w_pos_nxt   = 3'd0;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
    end
  end

  // Input sample stage and FSM/output registers.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_seg   <= 8'hFF;
      r_an    <= 8'hFF;
      r_state <= WAIT;
      r_dig   <= '0;
      r_pos   <= '0;
      r_cnt   <= '0;
      r_frame <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
    end else begin
      r_seg   <= uSEG_;
      r_an    <= uAN_;
      r_state <= w_state_nxt;
      r_dig   <= w_dig_nxt;
      r_pos   <= w_pos_nxt;
      r_cnt   <= w_cnt_nxt;
      r_frame <= w_frame_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_abort;
      r_code  <= w_abort ? w_abort_code : ERR_NONE;
    end
  end

  assign yTot     = r_frame.tot;
  assign yCur     = r_frame.cur;
  assign yWat     = r_frame.wat;
  assign yValid   = r_valid;
  assign yErr     = r_err;
  assign yErrCode = r_code;

endmodule
